// File: rtl/ofmap_demux.sv
// rtl/ofmap_demux.sv - reassembles serialized row beats into per-channel tiles
// and hands them downstream one channel at a time.
module ofmap_demux #(
    parameter int CHANNEL_N = 2,
    parameter int POX       = 4,
    parameter int POY       = 4,
    localparam int RW       = $clog2(POY + 1),
    localparam int CW       = $clog2(CHANNEL_N),
    localparam int RCW      = (POY > 1) ? $clog2(POY) : 1,
    localparam int BW       = POX * 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RW-1:0]           cfg_rows,
    input  logic [BW-1:0]           in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [POY*BW-1:0]       out_tile,
    output logic [CW-1:0]           out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_drop
);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                                  state_q, state_d;
    logic [RCW-1:0]                          row_q, row_d;
    logic [CW-1:0]                           ch_q, ch_d;
    logic [CW-1:0]                           drain_q, drain_d;
    logic [RW-1:0]                           rows_lat_q, rows_lat_d;
    logic                                    err_q, err_d;
    logic [CHANNEL_N-1:0][POY-1:0][BW-1:0]   mem_q, mem_d;

    logic [RW-1:0] cfg_clamped;
    logic [RW-1:0] rows_eff;
    logic          first_beat;
    logic          accept;
    logic          last_row;
    logic          last_ch;

    always_comb begin
        cfg_clamped = ((cfg_rows == '0) || (cfg_rows > RW'(POY))) ? RW'(POY) : cfg_rows;
        first_beat  = (state_q == FILL) && (ch_q == '0) && (row_q == '0);
        // The first beat of a group must compare against the new row count.
        rows_eff    = first_beat ? cfg_clamped : rows_lat_q;
        accept      = in_valid && (state_q == FILL);
        last_row    = (RW'(row_q) == (rows_eff - RW'(1)));
        last_ch     = (ch_q == CW'(CHANNEL_N - 1));

        state_d    = state_q;
        row_d      = row_q;
        ch_d       = ch_q;
        drain_d    = drain_q;
        rows_lat_d = rows_lat_q;
        err_d      = err_q | (in_valid && (state_q != FILL));
        mem_d      = mem_q;

        if (accept) begin
            if (first_beat) begin
                rows_lat_d = cfg_clamped;
                mem_d      = '0;
            end
            mem_d[ch_q][row_q] = in_data;
            if (last_row) begin
                row_d = '0;
                if (last_ch) begin
                    ch_d    = '0;
                    state_d = DRAIN;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end else begin
                row_d = row_q + RCW'(1);
            end
        end

        if ((state_q == DRAIN) && out_ready) begin
            if (drain_q == CW'(CHANNEL_N - 1)) begin
                drain_d = '0;
                state_d = FILL;
            end else begin
                drain_d = drain_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            row_q      <= '0;
            ch_q       <= '0;
            drain_q    <= '0;
            rows_lat_q <= '0;
            err_q      <= 1'b0;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            ch_q       <= ch_d;
            drain_q    <= drain_d;
            rows_lat_q <= rows_lat_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign out_tile  = mem_q[drain_q];
    assign out_ch    = drain_q;
    assign err_drop  = err_q;

endmodule

// File: tb/tb_ofmap_demux.sv
// tb/tb_ofmap_demux.sv - directed self-checking bench for ofmap_demux.
module tb_ofmap_demux;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   cfg_rows = 3'd4;
    logic [63:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] out_tile;
    logic [0:0]   out_ch;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         err_drop;

    int checks = 0;
    int failures = 0;

    ofmap_demux #(.CHANNEL_N(2), .POX(4), .POY(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_rows  (cfg_rows),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_tile  (out_tile),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rv(input logic [15:0] v);
        return {4{v}};
    endfunction

    function automatic logic [255:0] tile(input logic [15:0] r0, r1, r2, r3);
        return {rv(r3), rv(r2), rv(r1), rv(r0)};
    endfunction

    task automatic beat(input logic [15:0] v, input logic [2:0] rows);
        @(negedge clk);
        check("beat_in_ready", 256'(in_ready), 256'(1));
        cfg_rows = rows;
        in_data  = rv(v);
        in_valid = 1'b1;
    endtask

    task automatic gap();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain_chk(input logic ch, input logic [255:0] exp);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain_valid", 256'(out_valid), 256'(1));
        check("drain_in_ready", 256'(in_ready), 256'(0));
        check("drain_ch", 256'(out_ch), 256'(ch));
        check("drain_tile", out_tile, exp);
    endtask

    task automatic fill_chk();
        @(negedge clk);
        check("fill_in_ready", 256'(in_ready), 256'(1));
        check("fill_valid", 256'(out_valid), 256'(0));
    endtask

    task automatic group8(input logic [15:0] base, input logic [2:0] rows);
        for (int k = 0; k < 8; k++) beat(base + 16'(k), (k == 0) ? rows : 3'd1);
    endtask

    task automatic drain8(input logic [15:0] base);
        drain_chk(1'b0, tile(base, base + 16'd1, base + 16'd2, base + 16'd3));
        drain_chk(1'b1, tile(base + 16'd4, base + 16'd5, base + 16'd6, base + 16'd7));
        fill_chk();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_ch", 256'(out_ch), 256'(0));
        check("rst_tile", out_tile, '0);
        check("rst_err", 256'(err_drop), 256'(0));

        // basic fill and drain, later beats carry a bogus cfg_rows that must be ignored
        group8(16'h0000, 3'd4);
        drain8(16'h0000);

        // short rows
        beat(16'hA0A0, 3'd2); beat(16'hB0B0, 3'd2); beat(16'hC0C0, 3'd2); beat(16'hD0D0, 3'd2);
        drain_chk(1'b0, tile(16'hA0A0, 16'hB0B0, 16'h0, 16'h0));
        drain_chk(1'b1, tile(16'hC0C0, 16'hD0D0, 16'h0, 16'h0));
        fill_chk();

        // single row per channel
        beat(16'hE0E0, 3'd1); beat(16'hF0F0, 3'd1);
        drain_chk(1'b0, tile(16'hE0E0, 16'h0, 16'h0, 16'h0));
        drain_chk(1'b1, tile(16'hF0F0, 16'h0, 16'h0, 16'h0));
        fill_chk();

        // clamping
        group8(16'h0010, 3'd0);
        drain8(16'h0010);
        group8(16'h0020, 3'd7);
        drain8(16'h0020);

        // backpressure with beats offered during DRAIN
        out_ready = 1'b0;
        group8(16'h0030, 3'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 256'(out_valid), 256'(1));
            check("bp_in_ready", 256'(in_ready), 256'(0));
            check("bp_ch", 256'(out_ch), 256'(0));
            check("bp_tile", out_tile, tile(16'h30, 16'h31, 16'h32, 16'h33));
            in_valid = 1'b1;
            in_data  = rv(16'hDEAD);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_err", 256'(err_drop), 256'(1));
        check("bp_tile_end", out_tile, tile(16'h30, 16'h31, 16'h32, 16'h33));
        out_ready = 1'b1;
        drain_chk(1'b1, tile(16'h34, 16'h35, 16'h36, 16'h37));
        fill_chk();
        check("bp_err_sticky", 256'(err_drop), 256'(1));

        // gapped input
        for (int k = 0; k < 8; k++) begin
            beat(16'h0040 + 16'(k), 3'd4);
            if (k != 7) gap();
        end
        drain8(16'h0040);

        // reset mid-fill
        beat(16'h0050, 3'd4); beat(16'h0051, 3'd4); beat(16'h0052, 3'd4);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstf_in_ready", 256'(in_ready), 256'(1));
        check("rstf_valid", 256'(out_valid), 256'(0));
        check("rstf_err", 256'(err_drop), 256'(0));
        check("rstf_tile", out_tile, '0);
        group8(16'h0060, 3'd4);
        drain8(16'h0060);

        // reset mid-drain
        group8(16'h0070, 3'd4);
        drain_chk(1'b0, tile(16'h70, 16'h71, 16'h72, 16'h73));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstd_in_ready", 256'(in_ready), 256'(1));
        check("rstd_valid", 256'(out_valid), 256'(0));
        check("rstd_ch", 256'(out_ch), 256'(0));
        check("rstd_tile", out_tile, '0);
        group8(16'h0080, 3'd4);
        drain8(16'h0080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
